// File: rtl/divider_pkg.sv
// Shared types and helpers for the pipelined restoring divider.
// Payload fields are sized for the widest supported configuration; narrower
// instances use only the low bits and keep the upper bits at zero.
package divider_pkg;

  localparam int unsigned DIV_MAX_WIDTH     = 64;
  localparam int unsigned DIV_MAX_TAG_WIDTH = 8;

  // Encoding matches funct3[1:0] of the M-extension divide group
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  function automatic logic is_signed_op(div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem_op(div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

  // One pipeline slot: partial remainder, dividend/quotient shift register
  // (dividend MSBs leave at the top, quotient bits enter at the bottom),
  // magnitude divisor, untouched dividend for the divide-by-zero remainder,
  // result signs, special-case flags and the passthrough tag.
  typedef struct packed {
    logic                         valid;
    div_op_e                      op;
    logic                         q_neg;
    logic                         r_neg;
    logic                         dbz;
    logic                         ovf;
    logic [DIV_MAX_TAG_WIDTH-1:0] tag;
    logic [DIV_MAX_WIDTH-1:0]     rem;
    logic [DIV_MAX_WIDTH-1:0]     qd;
    logic [DIV_MAX_WIDTH-1:0]     dsr;
    logic [DIV_MAX_WIDTH-1:0]     orig;
  } div_stage_t;

endpackage

// File: rtl/divider_stage.sv
// One divider pipeline stage: BITS_PER_STAGE chained restoring iterations
// followed by the stage register with reset/flush/stall control.
module divider_stage
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_STAGE = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_stall,
  input  logic       i_flush,
  input  div_stage_t i_stage,
  output div_stage_t o_stage
);

  div_stage_t       w_nxt;
  div_stage_t       r_stage;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_qd;
  logic [WIDTH-1:0] w_dsr;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;

  // Restoring iterations. The partial remainder is always below the divisor,
  // so the shifted value is below 2*divisor and bit WIDTH of the
  // WIDTH+1-bit difference is exactly the borrow.
  always_comb begin
    w_nxt    = i_stage;
    w_rem    = i_stage.rem[WIDTH-1:0];
    w_qd     = i_stage.qd[WIDTH-1:0];
    w_dsr    = i_stage.dsr[WIDTH-1:0];
    w_sh     = '0;
    w_diff   = '0;
    w_borrow = 1'b0;
    for (int unsigned k = 0; k < BITS_PER_STAGE; k++) begin
      w_sh     = {w_rem, w_qd[WIDTH-1]};
      w_diff   = w_sh - {1'b0, w_dsr};
      w_borrow = w_diff[WIDTH];
      w_qd     = {w_qd[WIDTH-2:0], ~w_borrow};
      w_rem    = w_borrow ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
    end
    w_nxt.rem[WIDTH-1:0] = w_rem;
    w_nxt.qd[WIDTH-1:0]  = w_qd;
  end

  // Stage register: reset and flush kill the slot, stall freezes it
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_stage.valid <= 1'b0;
    end else if (!i_stall) begin
      r_stage <= w_nxt;
    end
  end

  assign o_stage = r_stage;

endmodule

// File: rtl/divider_pipelined.sv
// Fully pipelined restoring divider for the EX-stage ALU.
// Stage 0 registers operand magnitudes and special-case flags, then
// WIDTH/BITS_PER_STAGE divider_stage instances resolve the quotient.
// WIDTH must be even, >= 8 and <= 64; BITS_PER_STAGE must divide WIDTH;
// TAG_WIDTH must be <= 8.
// Optional macro DIVIDER_PIPELINED_OUTPUT_REG_EN adds an output register
// after result selection (one extra cycle of latency).
module divider_pipelined
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_STAGE = 2,
  parameter int unsigned TAG_WIDTH      = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  div_op_e              i_op,
  input  logic [WIDTH-1:0]     i_dividend,
  input  logic [WIDTH-1:0]     i_divisor,
  input  logic [TAG_WIDTH-1:0] i_tag,
  input  logic                 i_stall,
  input  logic                 i_flush,
  output logic                 o_valid,
  output logic [WIDTH-1:0]     o_result,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic                 o_busy
);

  localparam int unsigned     N_STAGES = WIDTH / BITS_PER_STAGE;
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic             w_sgn;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  div_stage_t       w_s0;
  div_stage_t       r_s0;
  div_stage_t       w_pipe [0:N_STAGES];
  logic [N_STAGES:0] w_vld;
  div_stage_t       w_last;
  logic             w_rem_op;
  logic             w_sgn_o;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_sel;
  logic             w_unused_last;

  // Stage 0 payload: magnitudes, result signs and special-case detection
  always_comb begin
    w_sgn   = is_signed_op(i_op);
    w_a_neg = w_sgn & i_dividend[WIDTH-1];
    w_b_neg = w_sgn & i_divisor[WIDTH-1];
    w_abs_a = w_a_neg ? (~i_dividend + WIDTH'(1)) : i_dividend;
    w_abs_b = w_b_neg ? (~i_divisor + WIDTH'(1)) : i_divisor;

    w_s0                    = '0;
    w_s0.valid              = i_valid;
    w_s0.op                 = i_op;
    w_s0.q_neg              = w_a_neg ^ w_b_neg;
    w_s0.r_neg              = w_a_neg;
    w_s0.dbz                = (i_divisor == '0);
    w_s0.ovf                = w_sgn && (i_dividend == MIN_INT) && (i_divisor == '1);
    w_s0.tag[TAG_WIDTH-1:0] = i_tag;
    w_s0.qd[WIDTH-1:0]      = w_abs_a;
    w_s0.dsr[WIDTH-1:0]     = w_abs_b;
    w_s0.orig[WIDTH-1:0]    = i_dividend;
  end

  // Input register; a flushed or stalled request is not captured
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_s0.valid <= 1'b0;
    end else if (!i_stall) begin
      r_s0 <= w_s0;
    end
  end

  assign w_pipe[0] = r_s0;

  // Iteration stages
  for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
    divider_stage #(
      .WIDTH          (WIDTH),
      .BITS_PER_STAGE (BITS_PER_STAGE)
    ) u_stage (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_stall (i_stall),
      .i_flush (i_flush),
      .i_stage (w_pipe[g]),
      .o_stage (w_pipe[g+1])
    );
  end

  // Valid bits of every slot for the busy indication
  for (genvar g = 0; g <= N_STAGES; g++) begin : g_vld
    assign w_vld[g] = w_pipe[g].valid;
  end

  assign w_last = w_pipe[N_STAGES];

  // Padding bits beyond WIDTH/TAG_WIDTH are carried but never selected
  assign w_unused_last = ^w_last;

  // Result select: divide-by-zero, then signed overflow, then sign fix-up
  always_comb begin
    w_rem_op = is_rem_op(w_last.op);
    w_sgn_o  = is_signed_op(w_last.op);
    w_q      = w_last.qd[WIDTH-1:0];
    w_r      = w_last.rem[WIDTH-1:0];
    w_sel    = w_q;
    if (w_last.dbz) begin
      w_sel = w_rem_op ? w_last.orig[WIDTH-1:0] : '1;
    end else if (w_last.ovf) begin
      w_sel = w_rem_op ? '0 : MIN_INT;
    end else if (w_rem_op) begin
      w_sel = (w_sgn_o && w_last.r_neg) ? (~w_r + WIDTH'(1)) : w_r;
    end else begin
      w_sel = (w_sgn_o && w_last.q_neg) ? (~w_q + WIDTH'(1)) : w_q;
    end
  end

`ifdef DIVIDER_PIPELINED_OUTPUT_REG_EN
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_out_result;
  logic [TAG_WIDTH-1:0] r_out_tag;

  // Output register with the same reset/flush/stall behaviour as the stages
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_out_valid <= 1'b0;
    end else if (!i_stall) begin
      r_out_valid  <= w_last.valid;
      r_out_result <= w_sel;
      r_out_tag    <= w_last.tag[TAG_WIDTH-1:0];
    end
  end

  assign o_valid  = r_out_valid;
  assign o_result = r_out_result;
  assign o_tag    = r_out_tag;
  assign o_busy   = (|w_vld) | r_out_valid;
`else
  assign o_valid  = w_last.valid;
  assign o_result = w_sel;
  assign o_tag    = w_last.tag[TAG_WIDTH-1:0];
  assign o_busy   = |w_vld;
`endif

endmodule

// File: tb/tb_divider_pipelined.sv
// Scoreboard bench for divider_pipelined: stimulus pushes expected results,
// a negedge monitor compares and pops whenever the DUT presents a result.
module tb_divider_pipelined;
  import divider_pkg::*;

  parameter int unsigned BPS = 2;
  localparam int unsigned W  = 32;
  localparam int unsigned TW = 5;
`ifdef DIVIDER_PIPELINED_OUTPUT_REG_EN
  localparam int unsigned LAT = W / BPS + 2;
`else
  localparam int unsigned LAT = W / BPS + 1;
`endif

  logic          i_clk;
  logic          i_rst;
  logic          i_valid;
  div_op_e       i_op;
  logic [W-1:0]  i_dividend;
  logic [W-1:0]  i_divisor;
  logic [TW-1:0] i_tag;
  logic          i_stall;
  logic          i_flush;
  logic          o_valid;
  logic [W-1:0]  o_result;
  logic [TW-1:0] o_tag;
  logic          o_busy;

  divider_pipelined #(
    .WIDTH          (W),
    .BITS_PER_STAGE (BPS),
    .TAG_WIDTH      (TW)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_op       (i_op),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .i_tag      (i_tag),
    .i_stall    (i_stall),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .o_result   (o_result),
    .o_tag      (o_tag),
    .o_busy     (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic plus the architected special cases
  function automatic logic [31:0] model(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return (op == DIV || op == DIVU) ? 32'hFFFF_FFFF : a;
    case (op)
      DIVU: return a / b;
      REMU: return a % b;
      default: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return (op == DIV) ? 32'h8000_0000 : 32'd0;
        if (op == DIV) return 32'($signed(a) / $signed(b));
        return 32'($signed(a) % $signed(b));
      end
    endcase
  endfunction

  // Monitor: compare presented result with the oldest expectation,
  // retire it only when the pipeline is not stalled
  always @(negedge i_clk) begin
    if (mon_en && o_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got result=%h tag=%0d, expected no result", o_result, o_tag);
      end else begin
        check("result", o_result, sb_q[0].res);
        check("tag", 32'(o_tag), 32'(sb_q[0].tag));
        if (!i_stall) void'(sb_q.pop_front());
      end
    end
  end

  task automatic drive(input div_op_e op, input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] tag);
    i_valid    = 1'b1;
    i_op       = op;
    i_dividend = a;
    i_divisor  = b;
    i_tag      = tag;
  endtask

  // Present one request for one clock edge; optionally expect its result
  task automatic issue(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TW-1:0] tag, input bit push, input logic [31:0] expv);
    exp_t e;
    drive(op, a, b, tag);
    if (push) begin
      e.res = expv;
      e.tag = tag;
      sb_q.push_back(e);
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  // Called right after issue(): counts cycles until the result appears
  task automatic measure_latency(input string name);
    int cnt;
    cnt = 1;
    while (o_valid !== 1'b1 && cnt < 200) begin
      @(posedge i_clk);
      #1;
      cnt++;
    end
    check(name, 32'(cnt), 32'(LAT));
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (sb_q.size() != 0 && c < 300) begin
      @(posedge i_clk);
      #1;
      c++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  div_op_e       r_ops [20];
  logic [31:0]   r_a   [20];
  logic [31:0]   r_b   [20];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst      = 1'b1;
    i_valid    = 1'b0;
    i_op       = DIV;
    i_dividend = '0;
    i_divisor  = '0;
    i_tag      = '0;
    i_stall    = 1'b0;
    i_flush    = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst  = 1'b0;
    mon_en = 1'b1;
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);

    // Basic divide with latency measurement
    issue(DIV, 32'd100, 32'd7, 5'd9, 1'b1, 32'd14);
    measure_latency("latency_div_100_7");
    wait_drain();

    // Directed signs and special cases, back to back
    issue(REM,  32'd100,       32'd7,         5'd9, 1'b1, 32'd2);
    issue(DIV,  32'hFFFF_FFF9, 32'd2,         5'd1, 1'b1, 32'hFFFF_FFFD);
    issue(REM,  32'hFFFF_FFF9, 32'd2,         5'd2, 1'b1, 32'hFFFF_FFFF);
    issue(DIVU, 32'hFFFF_FFF9, 32'd2,         5'd3, 1'b1, 32'h7FFF_FFFC);
    issue(DIVU, 32'h8000_0000, 32'd0,         5'd4, 1'b1, 32'hFFFF_FFFF);
    issue(REM,  32'h0000_1234, 32'd0,         5'd5, 1'b1, 32'h0000_1234);
    issue(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b1, 32'h8000_0000);
    issue(REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b1, 32'd0);
    wait_drain();

    // Reset mid-operation leaves nothing behind
    issue(DIVU, 32'd50, 32'd5, 5'd20, 1'b0, 32'd0);
    issue(DIVU, 32'd60, 32'd5, 5'd21, 1'b0, 32'd0);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("midop_reset_busy", 32'(o_busy), 32'd0);
    check("midop_reset_valid", 32'(o_valid), 32'd0);
    repeat (LAT + 3) @(posedge i_clk);
    #1;

    // 20 back-to-back ops with a 3-cycle stall while results stream out
    for (int i = 0; i < 20; i++) begin
      r_ops[i] = div_op_e'($urandom_range(0, 3));
      r_a[i]   = $urandom;
      r_b[i]   = $urandom >> $urandom_range(0, 31);
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 18) begin
        drive(r_ops[i], r_a[i], r_b[i], TW'(i));
        i_stall = 1'b1;
        repeat (3) begin
          @(posedge i_clk);
          #1;
          check("stall_holds_valid", 32'(o_valid), 32'd1);
        end
        i_stall = 1'b0;
      end
      issue(r_ops[i], r_a[i], r_b[i], TW'(i), 1'b1, model(r_ops[i], r_a[i], r_b[i]));
    end
    wait_drain();

    // Flush with 5 ops in flight plus a same-cycle request
    for (int i = 0; i < 5; i++) begin
      issue(DIVU, 32'd1000 + 32'(i), 32'd3, TW'(10 + i), 1'b0, 32'd0);
    end
    drive(DIV, 32'd77, 32'd7, 5'd15);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("flush_busy", 32'(o_busy), 32'd0);
    check("flush_valid", 32'(o_valid), 32'd0);
    issue(DIV, 32'd100, 32'd7, 5'd3, 1'b1, 32'd14);
    measure_latency("latency_after_flush");
    wait_drain();

    repeat (3) @(posedge i_clk);
    #1;
    check("final_busy", 32'(o_busy), 32'd0);
    check("final_queue_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/divider_pipelined.md
Name: divider_pipelined

Overview:
- Parametrised successor to the fixed radix-2, 2-bit-folded CPU divider. Fully pipelined restoring divider with configurable bits-per-stage and a 2-bit opcode.
- Selects quotient or remainder internally, carries a tag, and supports global stall and flush from the hazard unit.
- Sits in the EX-stage ALU; one result port feeds writeback.

Parameters:
- WIDTH, 32, operand/result width; must be even and >= 8
- BITS_PER_STAGE, 2, quotient bits resolved per pipeline stage; must divide WIDTH (1, 2, 4, 8 legal)
- TAG_WIDTH, 5, width of passthrough tag (destination register index)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_valid  in  1  operation request, captured when i_stall=0
- i_op  in  2  divider_pkg::div_op_e: DIV=00, DIVU=01, REM=10, REMU=11 (funct3[1:0])
- i_dividend  in  WIDTH  numerator
- i_divisor  in  WIDTH  denominator
- i_tag  in  TAG_WIDTH  opaque tag, returned with result
- i_stall  in  1  freeze entire pipeline
- i_flush  in  1  kill all in-flight operations
- o_valid  out  1  result valid
- o_result  out  WIDTH  quotient or remainder per op
- o_tag  out  TAG_WIDTH  tag of current result
- o_busy  out  1  any valid operation in flight (any stage valid bit set)

Behaviour:
- One clock, i_clk. Reset is synchronous, active-high, on i_rst.
- Stage count N = WIDTH/BITS_PER_STAGE.
- Latency is 1 (input register) + N cycles of unstalled operation; e.g. 17 for 32/2 and 9 for 32/4.
- Throughput is one op per unstalled cycle.
- Stage 0 (input register):
  - Signed ops (DIV, REM) take absolute values.
  - Registers quotient sign (dividend sign XOR divisor sign), remainder sign (dividend sign), op, tag and original dividend.
  - Registers div_by_zero (divisor==0).
  - Registers overflow (signed op, dividend==MIN_INT, divisor==all ones).
- Stages 1..N: each performs BITS_PER_STAGE chained restoring iterations.
  - Each iteration: shift the remainder left and bring in the next dividend MSB.
  - Subtract the divisor using a WIDTH+1-bit subtraction.
  - If the borrow is 0, set the quotient bit to 1 and keep the difference; otherwise restore.
- Output select, combinational from the last stage. Priority order:
  - div_by_zero: DIV/DIVU give all ones; REM/REMU give the original dividend, unmodified.
  - overflow: DIV gives MIN_INT and REM gives 0. Both are explicit muxes and must not rely on wraparound.
  - Otherwise: negate the quotient or remainder per the registered sign. Unsigned ops are never negated.
- Control priority each cycle is i_rst > i_flush > i_stall > normal.
- i_rst: all valid bits clear next cycle. Datapath registers are not reset.
- i_flush: all valid bits clear next cycle. An i_valid request in the same cycle is dropped.
- i_stall (no flush): every register, valid bits included, holds. i_valid is ignored and not captured; the requester must hold it.
- Reset values: o_valid=0 and o_busy=0 from the cycle after i_rst. o_result and o_tag are undefined until the first o_valid, and consumers must qualify them with o_valid.
- o_valid holds high while stalled on a valid result; the same result is presented until the stall releases.
- Reset or flush mid-operation leaves no residual valid output. A new op issued the cycle after flush completes normally.

Optional Feature:
- Macro: DIVIDER_PIPELINED_OUTPUT_REG_EN.
- Defined: o_result, o_tag and o_valid are registered after output select. Latency becomes N+2. The output register obeys the same stall, flush and reset rules, and o_busy includes its valid bit.
- Undefined: outputs are combinational from the last stage, with latency N+1.

Decomposition:
- divider_pkg holds:
  - div_op_e enum
  - helper functions is_signed_op(op) and is_rem_op(op)
  - a stage payload struct: remainder, quotient/dividend shift register, divisor, original dividend, signs, div_by_zero, overflow, op, tag, valid. It is parametrised via localparams or the maximum WIDTH.
- One sub-module, divider_stage, implements BITS_PER_STAGE restoring iterations plus the stage register with stall/flush/reset. It is instantiated N times in a generate loop.

Test Plan:
- DIV 100/7, default params: o_valid exactly 17 cycles after issue with result 14; REM same operands gives 2; tag 5'd9 returned.
- Signs: DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 gives 0x7FFFFFFC.
- Specials:
  - DIVU 0x80000000/0 gives 0xFFFFFFFF.
  - REM 0x1234/0 gives 0x1234.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000.
  - REM 0x80000000/0xFFFFFFFF gives 0.
- Back-to-back issue of 20 random ops with a 3-cycle i_stall mid-stream: results arrive in order, each matches the reference model, and there are no duplicates or drops. o_valid is held during the stall.
- i_flush with 5 ops in flight plus a same-cycle i_valid: no o_valid for those ops, and o_busy is 0 next cycle. An op issued the following cycle returns correctly after 17 cycles.
- Re-run with BITS_PER_STAGE=4 and with DIVIDER_PIPELINED_OUTPUT_REG_EN: latency is 9 and 18 respectively, and all directed results are unchanged.
